// File: rtl/som_sweep_pkg.sv
// Shared definitions for the SOM decoder sweep sequencer: FSM state codes,
// index/table widths and the golden truth tables of F = A(CD + B) + BC'.
package som_sweep_pkg;

    localparam int IDX_W   = 5;
    localparam int TT_W    = 16;
    localparam int DWELL_W = 8;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_RUN  = 2'd1;
    localparam state_t ST_DONE = 2'd2;

    localparam logic [TT_W-1:0] SOM_F_DIS = 16'h0000;
    localparam logic [TT_W-1:0] SOM_F_EN  = 16'hF830;

    localparam logic [IDX_W-1:0] IDX_ONE  = 5'd1;
    localparam logic [IDX_W-1:0] IDX_LAST = 5'd31;
    localparam logic [IDX_W-1:0] NO_ERR   = 5'h1F;

    // Golden F for sweep index i: bit i[3:0] of the table selected by E = i[4].
    function automatic logic golden_bit(input logic [TT_W-1:0] dis,
                                        input logic [TT_W-1:0] en,
                                        input logic [IDX_W-1:0] i);
        return i[4] ? en[i[3:0]] : dis[i[3:0]];
    endfunction

endpackage

// File: rtl/som_dwell_timer.sv
// Dwell counter for the sweep: counts 0..STEP_CYCLES-1 while run is high and
// flags the last cycle of each dwell with tick. clr forces the count to zero.
module som_dwell_timer
    import som_sweep_pkg::*;
#(
    parameter int unsigned STEP_CYCLES = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic run,
    output logic tick
);

    localparam logic [DWELL_W-1:0] LAST = DWELL_W'(STEP_CYCLES - 1);

    logic [DWELL_W-1:0] dwell;

    assign tick = run && (dwell == LAST);

    // Count up through the dwell, wrapping to zero on the sample cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dwell <= '0;
        end else if (clr) begin
            dwell <= '0;
        end else if (run) begin
            dwell <= tick ? '0 : dwell + 8'd1;
        end
    end

endmodule

// File: rtl/som_sweep_seq.sv
// Sweep sequencer for the SOM 2x4 decoder: walks {E,A,B,C,D} through all 32
// values, samples F on the last cycle of each dwell into two truth tables and
// flags whether both match the golden tables.
// Optional build macro SOM_SWEEP_ERRCNT_EN adds err_cnt / first_err outputs.
module som_sweep_seq
    import som_sweep_pkg::*;
#(
    parameter int unsigned     STEP_CYCLES = 1,
    parameter logic [TT_W-1:0] EXPECT_DIS  = SOM_F_DIS,
    parameter logic [TT_W-1:0] EXPECT_EN   = SOM_F_EN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    output logic [3:0]      abcd_out,
    output logic            en_out,
    input  logic            f_in,
    output logic            busy,
    output logic            done,
    output logic [TT_W-1:0] tt_dis,
    output logic [TT_W-1:0] tt_en,
    output logic            pass
`ifdef SOM_SWEEP_ERRCNT_EN
    ,
    output logic [5:0]      err_cnt,
    output logic [4:0]      first_err
`endif
);

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] idx_nxt;
    logic             running;
    logic             tick;
    logic [TT_W-1:0]  tt_dis_nxt;
    logic [TT_W-1:0]  tt_en_nxt;

    assign running = (state == ST_RUN);
    assign idx_nxt = idx + IDX_ONE;

    som_dwell_timer #(
        .STEP_CYCLES(STEP_CYCLES)
    ) u_dwell (
        .clk (clk),
        .rst (rst),
        .clr (!running),
        .run (running),
        .tick(tick)
    );

    // Tables as they will look once f_in is captured at the current index;
    // the final verdict must include the very last sample.
    always_comb begin
        tt_dis_nxt = tt_dis;
        tt_en_nxt  = tt_en;
        if (idx[4]) begin
            tt_en_nxt[idx[3:0]] = f_in;
        end else begin
            tt_dis_nxt[idx[3:0]] = f_in;
        end
    end

    // Sweep FSM: IDLE waits for start, RUN steps the index on each dwell tick,
    // DONE lasts one cycle to pulse done and publish the verdict.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            idx      <= '0;
            abcd_out <= '0;
            en_out   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            pass     <= 1'b0;
            tt_dis   <= '0;
            tt_en    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state    <= ST_RUN;
                        idx      <= '0;
                        abcd_out <= '0;
                        en_out   <= 1'b0;
                        busy     <= 1'b1;
                        pass     <= 1'b0;
                        tt_dis   <= '0;
                        tt_en    <= '0;
                    end
                end
                ST_RUN: begin
                    if (tick) begin
                        tt_dis <= tt_dis_nxt;
                        tt_en  <= tt_en_nxt;
                        idx    <= idx_nxt;
                        if (idx == IDX_LAST) begin
                            state    <= ST_DONE;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                            pass     <= (tt_dis_nxt == EXPECT_DIS) && (tt_en_nxt == EXPECT_EN);
                            abcd_out <= '0;
                            en_out   <= 1'b0;
                        end else begin
                            abcd_out <= idx_nxt[3:0];
                            en_out   <= idx_nxt[4];
                        end
                    end
                end
                ST_DONE: begin
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef SOM_SWEEP_ERRCNT_EN
    logic exp_bit;

    assign exp_bit = golden_bit(EXPECT_DIS, EXPECT_EN, idx);

    // Count mismatching captures as they happen and remember the first index.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt   <= '0;
            first_err <= NO_ERR;
        end else if ((state == ST_IDLE) && start) begin
            err_cnt   <= '0;
            first_err <= NO_ERR;
        end else if (running && tick && (f_in != exp_bit)) begin
            err_cnt <= err_cnt + 6'd1;
            if (first_err == NO_ERR) begin
                first_err <= idx;
            end
        end
    end
`endif

endmodule

// File: tb/tb_som_sweep_seq.sv
// Scoreboard bench for som_sweep_seq: two instances (dwell 1 and dwell 3)
// driven by a behavioural decoder that can be correct, stuck at 1, or blind
// to the enable input. Expected results are queued at each start and checked
// by a monitor when done pulses.
`timescale 1ns/1ps
module tb_som_sweep_seq;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic        start0 = 1'b0, start1 = 1'b0;
    int          mode0 = 0, mode1 = 0;
    logic [3:0]  abcd0, abcd1;
    logic        en0, en1, f0, f1, busy0, busy1, done0, done1, pass0, pass1;
    logic [15:0] dis0, dis1, ten0, ten1;
    logic [5:0]  ec0, ec1;
    logic [4:0]  fe0, fe1;

    // mode 0: correct decoder, 1: F stuck at 1, 2: decoder ignores E
    function automatic logic dec(input int m, input logic [3:0] v, input logic e);
        logic f;
        f = (v[3] & ((v[1] & v[0]) | v[2])) | (v[2] & ~v[1]);
        case (m)
            1:       return 1'b1;
            2:       return f;
            default: return e & f;
        endcase
    endfunction

    assign f0 = dec(mode0, abcd0, en0);
    assign f1 = dec(mode1, abcd1, en1);

    som_sweep_seq #(.STEP_CYCLES(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start0), .abcd_out(abcd0), .en_out(en0),
        .f_in(f0), .busy(busy0), .done(done0), .tt_dis(dis0), .tt_en(ten0),
        .pass(pass0)
`ifdef SOM_SWEEP_ERRCNT_EN
        , .err_cnt(ec0), .first_err(fe0)
`endif
    );

    som_sweep_seq #(.STEP_CYCLES(3)) u_dut3 (
        .clk(clk), .rst(rst), .start(start1), .abcd_out(abcd1), .en_out(en1),
        .f_in(f1), .busy(busy1), .done(done1), .tt_dis(dis1), .tt_en(ten1),
        .pass(pass1)
`ifdef SOM_SWEEP_ERRCNT_EN
        , .err_cnt(ec1), .first_err(fe1)
`endif
    );

`ifndef SOM_SWEEP_ERRCNT_EN
    assign ec0 = 6'd0;
    assign ec1 = 6'd0;
    assign fe0 = 5'h1F;
    assign fe1 = 5'h1F;
`endif

    typedef struct {
        logic [15:0] dis;
        logic [15:0] ten;
        logic        ok;
        int          len;
        int          erise;
        logic [5:0]  ec;
        logic [4:0]  fe;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input longint act, input longint req);
        n_chk++;
        if (act === req) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, req);
        end
    endtask

    function automatic exp_t mk(input logic [15:0] dis, input logic [15:0] ten, input logic ok,
                                input int step, input logic [5:0] ec, input logic [4:0] fe);
        exp_t e;
        e.dis = dis; e.ten = ten; e.ok = ok;
        e.len = 32 * step; e.erise = 16 * step;
        e.ec = ec; e.fe = fe;
        return e;
    endfunction

    // Per-instance monitor state: busy cycles this sweep, cycle en_out first
    // rose, count of drive-pattern errors, previous done.
    int   bcnt[2]  = '{0, 0};
    int   erise[2] = '{-1, -1};
    int   derr[2]  = '{0, 0};
    logic pdone[2] = '{1'b0, 1'b0};

    task automatic mon(input int d, input logic busy, input logic done, input logic [3:0] abcd,
                       input logic en, input logic [15:0] dis, input logic [15:0] ten,
                       input logic ok, input logic [5:0] ec, input logic [4:0] fe);
        exp_t e;
        int   st;
        int   sw;
        int   qs;
        st = (d == 0) ? 1 : 3;
        if (rst) begin
            bcnt[d] = 0; erise[d] = -1; derr[d] = 0; pdone[d] = 1'b0;
            return;
        end
        if (busy) begin
            sw = bcnt[d] / st;
            if (abcd != 4'(sw % 16) || en != (sw >= 16)) derr[d]++;
            if (en && erise[d] < 0) erise[d] = bcnt[d];
            bcnt[d]++;
        end
        if (pdone[d]) chk($sformatf("d%0d_done_width", d), done, 0);
        if (done) begin
            qs = (d == 0) ? q0.size() : q1.size();
            chk($sformatf("d%0d_sb_has_entry", d), qs > 0, 1);
            if (qs > 0) begin
                if (d == 0) e = q0.pop_front();
                else        e = q1.pop_front();
                chk($sformatf("d%0d_tt_dis", d), dis, e.dis);
                chk($sformatf("d%0d_tt_en", d), ten, e.ten);
                chk($sformatf("d%0d_pass", d), ok, e.ok);
                chk($sformatf("d%0d_busy_len", d), bcnt[d], e.len);
                chk($sformatf("d%0d_en_rise", d), erise[d], e.erise);
                chk($sformatf("d%0d_drive_errs", d), derr[d], 0);
                chk($sformatf("d%0d_busy_at_done", d), busy, 0);
                chk($sformatf("d%0d_abcd_at_done", d), {en, abcd}, 0);
`ifdef SOM_SWEEP_ERRCNT_EN
                chk($sformatf("d%0d_err_cnt", d), ec, e.ec);
                chk($sformatf("d%0d_first_err", d), fe, e.fe);
`else
                if (ec != e.ec && fe != e.fe) derr[d]++;
`endif
            end
            bcnt[d] = 0; erise[d] = -1; derr[d] = 0;
        end
        pdone[d] = done;
    endtask

    always @(negedge clk) begin
        mon(0, busy0, done0, abcd0, en0, dis0, ten0, pass0, ec0, fe0);
        mon(1, busy1, done1, abcd1, en1, dis1, ten1, pass1, ec1, fe1);
    end

    task automatic wait_done(input int d, input int maxc);
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!((d == 0) ? done0 : done1) && k < maxc);
        chk($sformatf("d%0d_done_seen", d), (d == 0) ? done0 : done1, 1);
    endtask

    task automatic pulse0();
        @(posedge clk); #1 start0 = 1'b1;
        @(posedge clk); #1 start0 = 1'b0;
    endtask

    task automatic pulse1();
        @(posedge clk); #1 start1 = 1'b1;
        @(posedge clk); #1 start1 = 1'b0;
    endtask

    initial begin
        logic seen;
        int   gap;

        // Reset and quiet idle
        #2 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_abcd", abcd0, 0);
        chk("rst_en", en0, 0);
        chk("rst_busy", busy0, 0);
        chk("rst_done", done0, 0);
        chk("rst_tt_dis", dis0, 0);
        chk("rst_tt_en", ten0, 0);
        chk("rst_pass", pass0, 0);
        chk("rst_d3_busy_tt", {busy1, dis1, ten1, pass1}, 0);
        seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (busy0 || busy1 || done0 || done1) seen = 1'b1;
        end
        chk("idle_no_activity", seen, 0);
        chk("idle_outputs", {abcd0, en0, pass0, dis0, ten0}, 0);

        // Correct decoder, dwell 1
        mode0 = 0;
        q0.push_back(mk(16'h0000, 16'hF830, 1'b1, 1, 6'd0, 5'h1F));
        pulse0();
        wait_done(0, 100);
        repeat (5) @(negedge clk);
        chk("pass_held", pass0, 1);

        // F stuck at 1, dwell 3
        mode1 = 1;
        q1.push_back(mk(16'hFFFF, 16'hFFFF, 1'b0, 3, 6'd25, 5'd0));
        pulse1();
        wait_done(1, 300);

        // Decoder blind to E, dwell 1
        mode0 = 2;
        q0.push_back(mk(16'hF830, 16'hF830, 1'b0, 1, 6'd7, 5'd4));
        pulse0();
        wait_done(0, 100);

        // Reset in the middle of a sweep, then a clean sweep
        mode0 = 0;
        @(posedge clk); #1 start0 = 1'b1;
        @(posedge clk); #1 start0 = 1'b0;
        repeat (9) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("midrst_busy", busy0, 0);
        chk("midrst_abcd_en", {en0, abcd0}, 0);
        chk("midrst_tables", {dis0, ten0}, 0);
        chk("midrst_done_pass", {done0, pass0}, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        q0.push_back(mk(16'h0000, 16'hF830, 1'b1, 1, 6'd0, 5'h1F));
        pulse0();
        wait_done(0, 100);

        // start held high across DONE, plus start pulses during RUN
        q0.push_back(mk(16'h0000, 16'hF830, 1'b1, 1, 6'd0, 5'h1F));
        q0.push_back(mk(16'h0000, 16'hF830, 1'b1, 1, 6'd0, 5'h1F));
        @(posedge clk); #1 start0 = 1'b1;
        wait_done(0, 100);
        gap = 0;
        @(negedge clk);
        while (!busy0 && gap < 10) begin
            gap++;
            @(negedge clk);
        end
        chk("idle_gap_after_done", gap, 1);
        repeat (4) @(posedge clk);
        #1 start0 = 1'b0;
        repeat (3) @(posedge clk);
        #1 start0 = 1'b1;
        @(posedge clk); #1 start0 = 1'b0;
        repeat (6) @(posedge clk);
        #1 start0 = 1'b1;
        @(posedge clk); #1 start0 = 1'b0;
        wait_done(0, 100);
        repeat (3) @(negedge clk);
        chk("no_extra_sweep", busy0, 0);

        chk("sb_drained", q0.size() + q1.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
